// File: rtl/mult_pkg.sv
// Shared types for the pipelined RV M-extension multiplier (mult_pipe).
package mult_pkg;

    localparam int MULT_XLEN  = 32;
    localparam int MULT_TAG_W = 6;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mult_func_t;

    typedef struct packed {
        logic                     valid;
        mult_func_t               func;
        logic [MULT_TAG_W-1:0]    tag;
        logic [2*MULT_XLEN-1:0]   acc;
        logic [2*MULT_XLEN-1:0]   mcand;
        logic [2*MULT_XLEN-1:0]   mplier;
    } mult_stage_t;

    function automatic logic [2*MULT_XLEN-1:0] sext_operand(input logic [MULT_XLEN-1:0] v,
                                                            input logic is_signed);
        return {{MULT_XLEN{is_signed & v[MULT_XLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: consumes NUM_BITS multiplier bits into the
// accumulator, shifts operands for the next stage, obeys global stall and flush.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int NUM_BITS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        advance,
    input  mult_stage_t stage_i,
    output mult_stage_t stage_o
);

    localparam int W = 2 * MULT_XLEN;

    logic [W-1:0] pp;

    // Zero-extended multiplier slice; everything wraps mod 2^W.
    assign pp = W'(stage_i.mplier[NUM_BITS-1:0]) * stage_i.mcand;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_o <= '0;
        end else if (flush) begin
            stage_o.valid <= 1'b0;
        end else if (advance) begin
            stage_o.valid  <= stage_i.valid;
            stage_o.func   <= stage_i.func;
            stage_o.tag    <= stage_i.tag;
            stage_o.acc    <= stage_i.acc + pp;
            stage_o.mcand  <= stage_i.mcand << NUM_BITS;
            stage_o.mplier <= stage_i.mplier >> NUM_BITS;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Stallable pipelined XLEN x XLEN multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough and flush.
// Define MULT_PIPE_PERF_EN to add perf_issued / perf_stall counters.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int XLEN      = MULT_XLEN,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = MULT_TAG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_func,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MULT_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int NUM_BITS = 2 * XLEN / NUM_STAGE;

    mult_stage_t entry_p0;
    mult_stage_t stg_q [NUM_STAGE];
    mult_stage_t last;
    mult_func_t  func_in;
    logic        advance;
    logic        accept;

    assign func_in  = mult_func_t'(in_func);
    assign last     = stg_q[NUM_STAGE-1];
    assign advance  = !last.valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && in_ready && !flush;

    // Entry register: operands sign-extended to 2*XLEN, accumulator cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_p0 <= '0;
        end else if (flush) begin
            entry_p0.valid <= 1'b0;
        end else if (advance) begin
            entry_p0.valid  <= accept;
            entry_p0.func   <= func_in;
            entry_p0.tag    <= in_tag;
            entry_p0.acc    <= '0;
            entry_p0.mcand  <= sext_operand(in_rs1, (func_in == MULH) || (func_in == MULHSU));
            entry_p0.mplier <= sext_operand(in_rs2, func_in == MULH);
        end
    end

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        mult_stage_t stage_in;
        if (i == 0) begin : g_first
            assign stage_in = entry_p0;
        end else begin : g_rest
            assign stage_in = stg_q[i-1];
        end
        mult_pipe_stage #(.NUM_BITS(NUM_BITS)) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .flush   (flush),
            .advance (advance),
            .stage_i (stage_in),
            .stage_o (stg_q[i])
        );
    end

    // Output stage: gated to zero whenever no result is presented.
    assign out_valid  = last.valid;
    assign out_result = !last.valid      ? '0 :
                        (last.func == MUL) ? last.acc[XLEN-1:0] : last.acc[2*XLEN-1:XLEN];
    assign out_tag    = last.valid ? last.tag : '0;

`ifdef MULT_PIPE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept)
                perf_issued <= perf_issued + 32'd1;
            if (last.valid && !out_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed table, stall/flush/reset sequences, random traffic vs a scoreboard.
module tb_mult_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_func = 2'd0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [5:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
`ifdef MULT_PIPE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    mult_pipe dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef MULT_PIPE_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
    } exp_t;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] want;
    } vec_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;

    // Reference: full-precision product using SystemVerilog signedness, then pick a half.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (f)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // One clock: score the handshakes that happen at the coming edge, then advance.
    task automatic tick();
        bit   acc, cons;
        exp_t e;
        #1;
        acc  = in_valid && in_ready && !flush;
        cons = out_valid && out_ready;
        if (cons) begin
            n_out++;
            if (sbq.size() == 0) begin
                check("unexpected_result", 64'(out_tag), 64'hFFFF);
            end else begin
                e = sbq.pop_front();
                check("result", 64'(out_result), 64'(e.res));
                check("tag", 64'(out_tag), 64'(e.tag));
            end
        end
        if (flush) sbq.delete();
        else if (acc) begin
            e.res = ref_mul(in_func, in_rs1, in_rs2);
            e.tag = in_tag;
            sbq.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic rand_op(input logic [5:0] tag);
        in_valid = 1'b1;
        in_func  = 2'($urandom);
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = tag;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) tick();
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        vec_t        vecs[7];
        int          lat;
        int          sent;
        logic        stalled_prev;
        logic [31:0] held_r;
        logic [5:0]  held_t;

        vecs[0] = '{2'b00, 32'd7,          32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB};
        vecs[1] = '{2'b01, 32'h80000000,   32'h80000000, 6'd1,  32'h40000000};
        vecs[2] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF, 6'd2,  32'hFFFFFFFE};
        vecs[3] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF, 6'd3,  32'hFFFFFFFF};
        vecs[4] = '{2'b01, 32'hFFFFFFFF,   32'd1,        6'd4,  32'hFFFFFFFF};
        vecs[5] = '{2'b11, 32'h80000000,   32'd2,        6'd63, 32'd1};
        vecs[6] = '{2'b00, 32'h00010000,   32'h00010000, 6'd9,  32'd0};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, with latency check
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_func  = vecs[i].f;
            in_rs1   = vecs[i].a;
            in_rs2   = vecs[i].b;
            in_tag   = vecs[i].tag;
            tick();
            in_valid = 1'b0;
            wait_out(lat);
            check("latency", 64'(lat), 64'd4);
            check("vec_result", 64'(out_result), 64'(vecs[i].want));
            check("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
            tick();
        end

        // 8 back-to-back ops with out_ready low on cycles 5..9
        n_out = 0;
        sent = 0;
        stalled_prev = 1'b0;
        for (int c = 0; c < 60 && !(sent == 8 && sbq.size() == 0); c++) begin
            out_ready = !(c >= 5 && c <= 9);
            if (sent < 8) rand_op(6'(sent + 16));
            else in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (stalled_prev) begin
                    check("stall_hold_result", 64'(out_result), 64'(held_r));
                    check("stall_hold_tag", 64'(out_tag), 64'(held_t));
                end
                held_r = out_result;
                held_t = out_tag;
            end
            stalled_prev = out_valid && !out_ready;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_results_count", 64'(n_out), 64'd8);
        check("stall_queue_empty", 64'(sbq.size()), 64'd0);

        // Flush with 3 in flight and a 4th presented
        for (int i = 0; i < 3; i++) begin
            rand_op(6'(i + 32));
            tick();
        end
        rand_op(6'd35);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        n_out = 0;
        for (int i = 0; i < 10; i++) tick();
        check("flush_no_leak", 64'(n_out), 64'd0);
        rand_op(6'd40);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("post_flush_latency", 64'(lat), 64'd4);
        tick();

        // Async reset with ops in flight and a result presented
        for (int i = 0; i < 4; i++) begin
            rand_op(6'(i + 48));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_out_result", 64'(out_result), 64'd0);
`ifdef MULT_PIPE_PERF_EN
        check("reset_perf_issued", 64'(perf_issued), 64'd0);
        check("reset_perf_stall", 64'(perf_stall), 64'd0);
`endif
        sbq.delete();
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        n_out = 0;
        for (int i = 0; i < 10; i++) tick();
        check("reset_no_leak", 64'(n_out), 64'd0);

        // 10 accepts, then 3 stall cycles
        for (int i = 0; i < 10; i++) begin
            rand_op(6'(i));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("perf_seq_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        drain();
`ifdef MULT_PIPE_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'd10);
        check("perf_stall", 64'(perf_stall), 64'd3);
`endif

        // Random traffic with back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) rand_op(6'($urandom));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(31) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drain();
        tick();
        check("final_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
